// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data memory between two masters.
//   Port 0 (CPU load/store) has fixed priority; port 1 (debug/DMA bridge) is
//   guaranteed a grant after STARVE_LIMIT lost arbitrations.
//   Optional macro DM_ARB_RR_EN swaps fixed priority + starvation guard for
//   round-robin arbitration driven by a last_served bit.
// Ports:
//   clk, reset (async, active low)
//   mX_req/we/addr/wdata  : master X request and payload (held until ack)
//   mX_ack/rdata          : access performed this cycle / read data during ack
//   dm_addr/dm_wd/dm_we   : to DM, driven from the latched payload
//   dm_rd                 : from DM, combinational in dm_addr
module dm_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wd,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rd
);

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    state_t        state;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wd;
    logic          lat_we;
    logic          grant0;
    logic          grant1;

`ifdef DM_ARB_RR_EN
    // last_served=1 after reset so port 0 wins the first contended round.
    logic last_served;

    assign grant1 = m1_req && (!m0_req || !last_served);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_served <= 1'b1;
        end else if (grant1) begin
            last_served <= 1'b1;
        end else if (grant0) begin
            last_served <= 1'b0;
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Number of consecutive edges port 1 has been waiting without a grant.
    logic [CNT_W-1:0] wait1;

    assign grant1 = m1_req && (!m0_req || wait1 == LIMIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait1 <= '0;
        end else if (m1_req && !grant1) begin
            if (wait1 != LIMIT) wait1 <= wait1 + 1'b1;
        end else begin
            wait1 <= '0;
        end
    end
`endif

    assign grant0 = m0_req && !grant1;

    // Grant and payload capture happen on the same edge; the SERVE cycle
    // then drives DM purely from the latches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lat_addr <= '0;
            lat_wd   <= '0;
            lat_we   <= 1'b0;
        end else if (grant1) begin
            state    <= SERVE1;
            lat_addr <= m1_addr;
            lat_wd   <= m1_wdata;
            lat_we   <= m1_we;
        end else if (grant0) begin
            state    <= SERVE0;
            lat_addr <= m0_addr;
            lat_wd   <= m0_wdata;
            lat_we   <= m0_we;
        end else begin
            state    <= IDLE;
        end
    end

    assign m0_ack   = (state == SERVE0);
    assign m1_ack   = (state == SERVE1);
    assign m0_rdata = m0_ack ? dm_rd : '0;
    assign m1_rdata = m1_ack ? dm_rd : '0;
    assign dm_addr  = lat_addr;
    assign dm_wd    = lat_wd;
    // Gated by state so an async reset mid-write kills the DM write at once.
    assign dm_we    = lat_we && (state != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wd;
    logic          dm_we;
    logic [DW-1:0] dm_rd;

    int checks = 0;
    int errors = 0;

    // Reference memory for the randomized region (words 64..255).
    logic [DW-1:0] ref_mem [0:1023];
    // Simple DM: combinational read, write on clock edge.
    logic [DW-1:0] dmem [0:1023];

    always #5 clk = ~clk;

    assign dm_rd = dmem[dm_addr[11:2]];
    always @(posedge clk) if (dm_we) dmem[dm_addr[11:2]] <= dm_wd;

    dm_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
    );

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({m0_ack, m1_ack, dm_we} !== 3'b000 || dm_addr !== '0 || dm_wd !== '0 ||
            m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_initial: ack0=%b ack1=%b we=%b addr=%h wd=%h r0=%h r1=%h expected all 0",
                     m0_ack, m1_ack, dm_we, dm_addr, dm_wd, m0_rdata, m1_rdata);
        end
        @(negedge clk);
        reset = 1;
        // Random traffic, then reset lands in the middle of a SERVE cycle.
        m0_req = 1; m0_we = 1; m0_addr = {$urandom_range(64, 255), 2'b00}; m0_wdata = $urandom;
        m1_req = $urandom_range(0, 1); m1_we = 1; m1_addr = {$urandom_range(64, 255), 2'b00};
        m1_wdata = $urandom;
        step();
        checks++;
        if (m0_ack !== 1'b1 || dm_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_serve: ack0=%b we=%b expected 1 1", m0_ack, dm_we);
        end
        reset = 0;
        #1;
        checks++;
        if ({m0_ack, m1_ack, dm_we} !== 3'b000 || dm_addr !== '0 || dm_wd !== '0 ||
            m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++;
            $display("FAIL reset_midrun: ack0=%b ack1=%b we=%b addr=%h wd=%h r0=%h r1=%h expected all 0",
                     m0_ack, m1_ack, dm_we, dm_addr, dm_wd, m0_rdata, m1_rdata);
        end
        idle_inputs();
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({m0_ack, m1_ack, dm_we} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_idle: ack0=%b ack1=%b we=%b expected 0 0 0",
                         m0_ack, m1_ack, dm_we);
            end
        end
    endtask

    task automatic test_port0_write_read();
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
        step();
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || dm_we !== 1'b1 ||
            dm_addr !== 32'h10 || dm_wd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_write: ack0=%b ack1=%b we=%b addr=%h wd=%h expected 1 0 1 00000010 deadbeef",
                     m0_ack, m1_ack, dm_we, dm_addr, dm_wd);
        end
        m0_we = 0; m0_wdata = '0;
        step();
        checks++;
        if (m0_ack !== 1'b1 || dm_we !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p0_read: ack0=%b we=%b rdata=%h expected 1 0 deadbeef",
                     m0_ack, dm_we, m0_rdata);
        end
        m0_req = 0;
        step();
        checks++;
        if (m0_ack !== 1'b0 || m0_rdata !== '0) begin
            errors++;
            $display("FAIL p0_idle: ack0=%b rdata=%h expected 0 0", m0_ack, m0_rdata);
        end
    endtask

`ifndef DM_ARB_RR_EN
    task automatic test_contention();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
        step();
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL contention_c1: ack0=%b ack1=%b r0=%h expected 1 0 deadbeef",
                     m0_ack, m1_ack, m0_rdata);
        end
        m0_req = 0;
        step();
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b1 || dm_we !== 1'b1 ||
            dm_addr !== 32'h20 || dm_wd !== 32'h12345678) begin
            errors++;
            $display("FAIL contention_c2: ack0=%b ack1=%b we=%b addr=%h wd=%h expected 0 1 1 00000020 12345678",
                     m0_ack, m1_ack, dm_we, dm_addr, dm_wd);
        end
        m1_we = 0; m1_wdata = '0;
        step();
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h12345678 || m0_rdata !== '0) begin
            errors++;
            $display("FAIL contention_readback: ack1=%b r1=%h r0=%h expected 1 12345678 0",
                     m1_ack, m1_rdata, m0_rdata);
        end
        m1_req = 0;
        step();
    endtask

    task automatic test_starvation();
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        // Port 1 wins every (LIMIT+1)-th cycle: cycles 5 and 10.
        for (int c = 1; c <= 10; c++) begin
            bit exp1;
            step();
            exp1 = (c % (LIMIT + 1)) == 0;
            checks++;
            if (m1_ack !== exp1 || m0_ack !== !exp1) begin
                errors++;
                $display("FAIL starvation_cycle%0d: ack0=%b ack1=%b expected %b %b",
                         c, m0_ack, m1_ack, !exp1, exp1);
            end
        end
        idle_inputs();
        step();
    endtask
`else
    task automatic test_rr();
        reset = 0;
        #1;
        reset = 1;
        @(negedge clk);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h20;
        for (int c = 1; c <= 6; c++) begin
            bit exp1;
            step();
            exp1 = (c % 2) == 0;
            checks++;
            if (m1_ack !== exp1 || m0_ack !== !exp1) begin
                errors++;
                $display("FAIL rr_cycle%0d: ack0=%b ack1=%b expected %b %b",
                         c, m0_ack, m1_ack, !exp1, exp1);
            end
        end
        idle_inputs();
        step();
    endtask
`endif

    task automatic test_reset_mid_write();
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'hCAFEF00D;
        step();
        checks++;
        if (m1_ack !== 1'b1 || dm_we !== 1'b1) begin
            errors++;
            $display("FAIL midwrite_serve: ack1=%b we=%b expected 1 1", m1_ack, dm_we);
        end
        reset = 0;
        #1;
        checks++;
        if (dm_we !== 1'b0 || m1_ack !== 1'b0) begin
            errors++;
            $display("FAIL midwrite_drop: we=%b ack1=%b expected 0 0", dm_we, m1_ack);
        end
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        m1_req = 1; m1_we = 0; m1_addr = 32'h40;
        step();
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL midwrite_readback: ack1=%b r1=%h expected 1 00000000", m1_ack, m1_rdata);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_random();
        bit            pend [2];
        bit            pwe  [2];
        logic [AW-1:0] paddr[2];
        logic [DW-1:0] pwd  [2];
        int            served = -1;
        bit            swe  = 0;
        logic [AW-1:0] saddr = '0;
        logic [DW-1:0] swd  = '0;
        int            lost1 = 0;
        bit            last = 1;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pwe[p] = 0; paddr[p] = '0; pwd[p] = '0;
        end
        reset = 0;
        #1;
        reset = 1;
        @(negedge clk);
        for (int cyc = 0; cyc < 500; cyc++) begin
            bit w0, w1;
            logic [DW-1:0] er0, er1;
            // Compare the cycle the model predicted at the last edge.
            er0 = (served == 0) ? ref_mem[saddr[11:2]] : '0;
            er1 = (served == 1) ? ref_mem[saddr[11:2]] : '0;
            checks++;
            if (m0_ack !== (served == 0) || m1_ack !== (served == 1) ||
                m0_rdata !== er0 || m1_rdata !== er1 ||
                dm_we !== (served >= 0 && swe) ||
                (served >= 0 && (dm_addr !== saddr || (swe && dm_wd !== swd)))) begin
                errors++;
                $display("FAIL random_cyc%0d: ack0=%b ack1=%b r0=%h r1=%h we=%b addr=%h wd=%h expected served=%0d r0=%h r1=%h we=%b addr=%h wd=%h",
                         cyc, m0_ack, m1_ack, m0_rdata, m1_rdata, dm_we, dm_addr, dm_wd,
                         served, er0, er1, swe, saddr, swd);
            end
            if (served >= 0 && swe) ref_mem[saddr[11:2]] = swd;
            if (served >= 0) pend[served] = 0;
            // Masters: idle ones may issue a fresh request; pending ones hold.
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 99) < 60) begin
                    pend[p]  = 1;
                    pwe[p]   = $urandom_range(0, 1);
                    paddr[p] = {$urandom_range(64, 255), 2'b00};
                    pwd[p]   = $urandom;
                end
            end
            m0_req = pend[0];
            m0_we  = pend[0] ? pwe[0] : 1'($urandom_range(0, 1));
            m0_addr = pend[0] ? paddr[0] : AW'($urandom);
            m0_wdata = pend[0] ? pwd[0] : DW'($urandom);
            m1_req = pend[1];
            m1_we  = pend[1] ? pwe[1] : 1'($urandom_range(0, 1));
            m1_addr = pend[1] ? paddr[1] : AW'($urandom);
            m1_wdata = pend[1] ? pwd[1] : DW'($urandom);
            // Arbitration decision for the coming edge.
`ifdef DM_ARB_RR_EN
            w1 = pend[1] && (!pend[0] || !last);
            w0 = pend[0] && !w1;
            if (w1) last = 1;
            else if (w0) last = 0;
`else
            w1 = pend[1] && (!pend[0] || lost1 == LIMIT);
            w0 = pend[0] && !w1;
            if (pend[1] && !w1) lost1 = (lost1 < LIMIT) ? lost1 + 1 : LIMIT;
            else lost1 = 0;
`endif
            served = w1 ? 1 : (w0 ? 0 : -1);
            if (served >= 0) begin
                swe = pwe[served]; saddr = paddr[served]; swd = pwd[served];
            end else begin
                swe = 0;
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            dmem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 0;
        idle_inputs();
        test_reset();
        test_port0_write_read();
`ifndef DM_ARB_RR_EN
        test_contention();
        test_starvation();
`else
        test_rr();
`endif
        test_reset_mid_write();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single data memory (DM) between two masters: port 0 is the CPU load/store stage, port 1 is a secondary master (debug loader / DMA-style bridge).
- Registered req/ack handshake, one DM access per cycle.
- Fixed priority to port 0, with a starvation guard that forces a port-1 grant after a bounded wait.
- Sits between the masters and DM. Drives DM address, write data and write enable, and returns DM read data to the served master.

Parameters:
- AW, 32, address width (full byte address forwarded to DM).
- DW, 32, data width.
- STARVE_LIMIT, 4, number of lost arbitrations port 1 tolerates before a forced grant (1..7).
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write (1) / read (0).
- m0_addr  in  AW  port 0 byte address.
- m0_wdata  in  DW  port 0 write data.
- m0_ack  out  1  port 0 access performed this cycle.
- m0_rdata  out  DW  port 0 read data, valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as port 0, for port 1.
- dm_addr  out  AW  to DM address.
- dm_wd  out  DW  to DM write data.
- dm_we  out  1  to DM write enable.
- dm_rd  in  DW  from DM read data (combinational in dm_addr).

Behaviour:
- States: IDLE, SERVE0, SERVE1. The state register is updated on each rising clk edge, and the next state is evaluated at every edge from any state:
  - m1 is granted if m1_req=1 and (m0_req=0 or wait1==STARVE_LIMIT); next state SERVE1.
  - Otherwise, if m0_req=1, next state SERVE0.
  - Otherwise, next state IDLE.
- On a grant, the winner's addr/we/wdata are latched into the payload registers on that same edge.
- In SERVE cycles, DM is driven from the payload registers, not from the live master inputs:
  - dm_addr and dm_wd come from the latches.
  - dm_we = latched_we in SERVEx, 0 in IDLE.
- Acks and read data:
  - mx_ack = (state==SERVEx).
  - mx_rdata = dm_rd when mx_ack=1, else 0.
  - A write completes at the edge closing the ack cycle, since DM writes on its clock edge.
- Handshake rules:
  - A master holds req and its payload stable until it sees ack.
  - req sampled high at the edge closing that master's ack cycle is a new request. A master with no further access drops req combinationally on seeing ack.
  - Back-to-back accesses by one master give one access per cycle.
- Latency: a request sampled at edge E with no contention is acked in the cycle following E. A port-0 request losing to a starvation grant waits exactly one extra cycle.
- Starvation counter wait1:
  - Increments, saturating at STARVE_LIMIT, at each edge where m1_req=1 and m1 is not granted.
  - Clears to 0 at each edge where m1 is granted or m1_req=0.
- Simultaneous requests: port 0 wins unless wait1==STARVE_LIMIT.
- Reset (reset=0, asynchronous):
  - state=IDLE; wait1=0; payload latches=0.
  - Outputs: m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, dm_we=0, dm_addr=0, dm_wd=0.
  - Reset during a SERVE write cycle drops dm_we immediately, so no DM write occurs. The master sees no ack and must reissue the request after reset.
- The arbiter does not drive DM's own reset; DM is reset separately.
- Addresses are forwarded unmodified. Word selection, using addr[11:2], is done inside DM.

Optional Feature:
- Macro DM_ARB_RR_EN.
- Defined: fixed priority and the starvation counter are replaced by round-robin arbitration.
  - A 1-bit last_served register, reset to 1, records the port served most recently.
  - On contention the port not equal to last_served wins.
  - A single requester always wins.
  - wait1 is removed.
- Undefined: fixed priority with the starvation guard, as described in Behaviour.

Test Plan:
- Reset: drive reset=0 mid-run with random requests -> all acks, dm_we, dm_addr, dm_wd and both rdata are 0 immediately. Release reset with no requests -> state stays IDLE, dm_we=0.
- Port 0 write then read:
  - m0 writes 0xDEADBEEF to 0x00000010 -> next cycle m0_ack=1, dm_we=1, dm_addr=0x10, dm_wd=0xDEADBEEF.
  - m0 then reads 0x10 -> m0_rdata=0xDEADBEEF during ack.
- Contention: m0 reads 0x10 while m1 writes 0x12345678 to 0x20, both in the same cycle -> m0_ack in cycle 1, m1_ack in cycle 2. A subsequent m1 read of 0x20 returns 0x12345678.
- Starvation (STARVE_LIMIT=4): m0_req and m1_req held high continuously -> m0 acked in cycles 1-4, m1 acked in cycle 5, then m0 again with wait1 restarting from 0.
- Reset mid-write: m1 writes 0xCAFEF00D to 0x40, and reset=0 is asserted during its SERVE1 cycle -> dm_we falls with reset, and a later read of 0x40 returns its prior value 0.
- DM_ARB_RR_EN defined: both requests held high for 6 cycles -> acks alternate m0, m1, m0, m1, m0, m1 (first grant m0, since last_served resets to 1).
